// File: rtl/otter_lsu.sv
// otter_lsu: ALU-fed load/store unit; core side mem_req_valid/ready, mem_we/size/unsigned, addr, wdata -> rsp_valid, rdata, err; bus side bus_addr/wdata/be/we/rd -> bus_ack, bus_rdata
module otter_lsu #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic        bus_we,
  output logic        bus_rd,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, nstate;
  logic [15:0] cnt;
  logic [1:0] lo, sz;
  logic uns, we, acc, bad, tout;
  logic [7:0] byt;
  logic [15:0] hlf;
  logic [31:0] ld;
  assign acc = mem_req_valid && mem_req_ready;
  assign bad = mem_size == 2'b11 || (mem_size == 2'b01 && addr[0]) || (mem_size == 2'b10 && addr[1:0] != 2'b00);
  assign tout = cnt == 16'(TIMEOUT_CYC - 1);
  assign byt = bus_rdata[{lo, 3'b000} +: 8];
  assign hlf = lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  assign ld = we ? '0
            : sz == 2'b00 ? {{24{!uns && byt[7]}}, byt}
            : sz == 2'b01 ? {{16{!uns && hlf[15]}}, hlf}
            : bus_rdata;
  always_comb begin
    nstate = state == IDLE ? (acc ? (bad ? RESP : BUSY) : IDLE)
           : state == BUSY ? (bus_ack || tout ? RESP : BUSY)
           : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nstate;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
      bus_addr <= '0;
      bus_wdata <= '0;
      bus_be <= '0;
      bus_we <= 1'b0;
      bus_rd <= 1'b0;
      cnt <= '0;
      lo <= '0;
      sz <= '0;
      uns <= 1'b0;
      we <= 1'b0;
    end else begin
      mem_req_ready <= nstate == IDLE;
      rsp_valid <= nstate == RESP;
      cnt <= state == BUSY ? cnt + 16'd1 : 16'd0;
      if (state == IDLE && acc) begin
        lo <= addr[1:0];
        sz <= mem_size;
        uns <= mem_unsigned;
        we <= mem_we;
        if (bad) begin
          err <= 1'b1;
          rdata <= '0;
        end else begin
          bus_addr <= {addr[31:2], 2'b00};
          bus_be <= mem_size == 2'b00 ? 4'b0001 << addr[1:0] : mem_size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
          bus_wdata <= mem_size == 2'b00 ? {4{wdata[7:0]}} : mem_size == 2'b01 ? {2{wdata[15:0]}} : wdata;
          bus_we <= mem_we;
          bus_rd <= !mem_we;
        end
      end
      if (state == BUSY && nstate == RESP) begin
        bus_we <= 1'b0;
        bus_rd <= 1'b0;
        bus_be <= '0;
        err <= !bus_ack;
        rdata <= bus_ack ? ld : '0;
      end
    end
  end
endmodule

// File: tb/tb_otter_lsu.sv
// tb_otter_lsu: randomized and directed checks of otter_lsu against a transaction-level schedule model
module tb_otter_lsu;
  localparam int TO = 4;
  logic clk = 0, rst = 1, mem_req_valid = 0, mem_we = 0, mem_unsigned = 0, bus_ack = 0;
  logic [1:0] mem_size = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic mem_req_ready, rsp_valid, err, bus_we, bus_rd;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  int cyc = 0, errors = 0, checks = 0, w_lo = 1, w_hi = 0, exp_rsp = -1, idle_from = 0;
  logic [31:0] exp_rdata = 0, exp_addr = 0, exp_wdata = 0, last_rdata = 0;
  logic [3:0] exp_be = 0;
  logic exp_err = 0, exp_we = 0, en = 0, inw = 0;

  otter_lsu #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rdata(rdata), .err(err), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_we(bus_we), .bus_rd(bus_rd), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    w_lo = 1;
    w_hi = 0;
    exp_rsp = -1;
    idle_from = cyc;
  endtask

  always @(negedge clk) if (en) begin
    inw = cyc >= w_lo && cyc <= w_hi;
    chk("ready", mem_req_ready, cyc > idle_from);
    chk("rsp_valid", rsp_valid, cyc == exp_rsp);
    if (cyc == exp_rsp) begin
      chk("rdata", rdata, exp_rdata);
      chk("err", err, exp_err);
      last_rdata = rdata;
    end
    chk("bus_rd", bus_rd, inw && !exp_we);
    chk("bus_we", bus_we, inw && exp_we);
    chk("bus_be", bus_be, inw ? exp_be : 4'd0);
    if (inw) begin
      chk("bus_addr", bus_addr, exp_addr);
      chk("bus_wdata", bus_wdata, exp_wdata);
    end
  end

  task automatic access(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] memd, input int waits, input int abort,
                        input logic lit_en, input logic [31:0] lit);
    int t, nb, k;
    logic bad, ackd;
    logic [31:0] mask, v;
    k = 0;
    while (!mem_req_ready && k < 20) begin
      tick;
      k++;
    end
    if (!mem_req_ready) begin
      chk("ready_wait", mem_req_ready, 1);
      return;
    end
    mem_req_valid = 1;
    mem_we = we;
    mem_size = sz;
    mem_unsigned = uns;
    addr = a;
    wdata = wd;
    bad = sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    nb = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    mask = nb == 4 ? 32'hFFFFFFFF : (32'd1 << (8 * nb)) - 1;
    v = (memd >> (8 * (a % 4))) & mask;
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
    ackd = waits < TO;
    tick;
    t = cyc;
    mem_req_valid = 0;
    mem_we = 1'($urandom);
    mem_size = 2'($urandom);
    mem_unsigned = 1'($urandom);
    addr = $urandom;
    wdata = $urandom;
    exp_we = we;
    exp_be = 4'(((1 << nb) - 1) << (a % 4));
    exp_addr = a & ~32'd3;
    exp_wdata = nb == 1 ? wd[7:0] * 32'h01010101 : nb == 2 ? wd[15:0] * 32'h00010001 : wd;
    exp_err = bad || !ackd;
    exp_rdata = (exp_err || we) ? 32'd0 : v;
    if (bad) begin
      w_lo = 1;
      w_hi = 0;
      exp_rsp = t;
    end else begin
      w_lo = t;
      w_hi = ackd ? t + waits : t + TO - 1;
      exp_rsp = w_hi + 1;
    end
    idle_from = exp_rsp;
    while (cyc <= exp_rsp) begin
      if (abort >= 0 && cyc == t + abort) begin
        bus_ack = 0;
        rst = 1;
        tick;
        model_reset;
        rst = 0;
        return;
      end
      bus_ack = (cyc == exp_rsp) ? 1'($urandom) : (cyc == t + waits && !bad);
      bus_rdata = (bus_ack && cyc != exp_rsp) ? memd : $urandom;
      tick;
    end
    bus_ack = 0;
    if (lit_en) chk("lit_rdata", last_rdata, lit);
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    repeat (2) tick;
    model_reset;
    chk("rst_ctl", {27'd0, mem_req_ready, rsp_valid, err, bus_rd, bus_we}, 32'd0);
    chk("rst_be", bus_be, 4'd0);
    chk("rst_rdata", rdata, 32'd0);
    en = 1;
    rst = 0;
    access(0, 2, 0, 32'h1000, 0, 32'hDEADBEEF, 0, -1, 1, 32'hDEADBEEF);
    access(0, 0, 0, 32'h1003, 0, 32'h80FF0000, 0, -1, 1, 32'hFFFFFF80);
    access(0, 0, 1, 32'h1003, 0, 32'h80FF0000, 1, -1, 1, 32'h00000080);
    access(0, 1, 0, 32'h1002, 0, 32'h80FF0000, 0, -1, 1, 32'hFFFF80FF);
    access(1, 1, 0, 32'h2002, 32'h1234ABCD, 32'h0, 3, -1, 1, 32'h0);
    access(0, 2, 0, 32'h3001, 0, 32'h5555, 0, -1, 1, 32'h0);
    access(0, 3, 0, 32'h0, 0, 32'h5555, 0, -1, 1, 32'h0);
    access(0, 2, 0, 32'h4000, 0, 32'h1111, 100, -1, 1, 32'h0);
    tick;
    bus_ack = 1;
    bus_rdata = $urandom;
    repeat (2) tick;
    bus_ack = 0;
    access(0, 2, 0, 32'h5000, 0, 32'h2222, 100, 1, 0, 32'h0);
    tick;
    access(0, 2, 0, 32'h6000, 0, 32'hCAFEF00D, 0, -1, 1, 32'hCAFEF00D);
    for (int i = 0; i < 200; i++) begin
      sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      a = $urandom;
      if ($urandom % 4 != 0) a[1:0] = sz == 2 ? 2'b00 : sz == 1 ? {a[1], 1'b0} : a[1:0];
      access(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 5), -1, 0, 32'h0);
      if ($urandom % 3 == 0) tick;
    end
    repeat (2) tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/otter_lsu.md
Name: otter_lsu

Overview:
Load/store unit directly downstream of the OTTER ALU. Takes the ALU RESULT as the effective address and rs2 as store data. Drives a single-outstanding-request word-addressed memory bus and returns sign/zero-extended load data for writeback. Multi-cycle: a handshake with the core, a wait-for-acknowledge bus cycle with timeout, and a one-cycle response.

Parameters:
TIMEOUT_CYC, 255, BUSY cycles without BUS_ACK before the access is aborted with ERR (legal range 1..65535)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous, active-high reset
MEM_REQ_VALID  in  1  core presents a load/store request
MEM_REQ_READY  out  1  LSU can accept a request this cycle
MEM_WE  in  1  1 = store, 0 = load
MEM_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal
MEM_UNSIGNED  in  1  1 = zero-extend load (LBU/LHU); ignored for stores and words
ADDR  in  32  effective byte address (ALU RESULT)
WDATA  in  32  store data (rs2), right-aligned
RSP_VALID  out  1  one-cycle pulse: access complete
RDATA  out  32  extended load data; 0 for stores and errors
ERR  out  1  qualifies RSP_VALID: misaligned, illegal size, or timeout
BUS_ADDR  out  32  word-aligned address ({ADDR[31:2],2'b00})
BUS_WDATA  out  32  lane-replicated store data
BUS_BE  out  4  byte enables
BUS_WE  out  1  write strobe
BUS_RD  out  1  read strobe
BUS_ACK  in  1  memory done; sampled only in BUSY
BUS_RDATA  in  32  read data, valid with BUS_ACK

Behaviour:
- States: IDLE, BUSY, RESP. Reset state is IDLE.
- Reset values: all registered outputs 0, including MEM_REQ_READY, RSP_VALID, ERR, BUS_RD, BUS_WE, BUS_BE and RDATA.
- MEM_REQ_READY = 1 only in IDLE, and only after reset has been deasserted for at least one edge. It is registered, not combinational from MEM_REQ_VALID.
- Accept occurs on an edge with MEM_REQ_VALID && MEM_REQ_READY. ADDR, MEM_SIZE, MEM_UNSIGNED and MEM_WE are latched at accept; later input changes are ignored.
- Alignment check at accept:
  - Half access with ADDR[0]=1 is an error.
  - Word access with ADDR[1:0]!=0 is an error.
  - MEM_SIZE=11 is an error.
  - On error: go to RESP directly, no bus strobe ever asserted, ERR=1, RDATA=0.
- Legal access: go to BUSY. BUS_ADDR, BUS_BE, BUS_WDATA, and BUS_WE or BUS_RD are valid in the first BUSY cycle. They are held stable until the BUSY exit edge, then deasserted (strobes and BE to 0).
- Byte lanes:
  - Byte: BE = 4'b0001 << ADDR[1:0]; BUS_WDATA = {4{WDATA[7:0]}}.
  - Half: BE = ADDR[1] ? 1100 : 0011; BUS_WDATA = {2{WDATA[15:0]}}.
  - Word: BE = 1111; BUS_WDATA = WDATA.
  - BE is driven for loads as well.
- BUSY:
  - BUS_ACK=1 on an edge: capture BUS_RDATA and go to RESP with ERR=0.
  - Cycle counter starts at 0 on entry. When it reaches TIMEOUT_CYC-1 with no ack, go to RESP with ERR=1 and RDATA=0.
  - An ack arriving on that same edge wins: no error.
- Load extraction from captured data:
  - Select byte lane ADDR[1:0], or half lane ADDR[1].
  - Sign-extend bit 7/15 unless MEM_UNSIGNED; word passes through.
  - Stores return RDATA=0.
- RESP: RSP_VALID=1 for exactly one cycle, then IDLE (READY=1 next cycle).
  - RDATA and ERR are meaningful only while RSP_VALID=1.
  - Both hold their value until the next response.
- Latency from the accept edge t:
  - Error: RSP_VALID high in cycle t+1.
  - Zero-wait ack (ack high in the first BUSY cycle): RSP_VALID in cycle t+2.
  - Each wait cycle adds one.
  - Back-to-back throughput is one access per 3 cycles minimum.
- BUS_ACK outside BUSY is ignored: no state change, no capture.
- RST mid-access (any state): the next edge returns to IDLE with all outputs at reset values. The strobe drops and no RSP_VALID is produced for the abandoned access.

Test Plan:
- Load word: ADDR=0x1000, SIZE=10, BUS_RDATA=0xDEADBEEF, ack in first BUSY cycle. Response: BUS_ADDR=0x1000, BE=1111, BUS_RD=1; RSP_VALID at t+2, RDATA=0xDEADBEEF, ERR=0.
- Byte load extension: ADDR=0x1003, BUS_RDATA=0x80FF_0000, signed byte. Response: BE=1000, RDATA=0xFFFFFF80. Same with MEM_UNSIGNED=1: RDATA=0x00000080. Half at ADDR=0x1002 signed: RDATA=0xFFFF80FF.
- Store half: ADDR=0x2002, WDATA=0x1234ABCD, ack after 3 wait cycles. Response: BUS_WE=1, BE=1100, BUS_WDATA=0xABCDABCD, all held stable for 4 cycles; RSP_VALID at t+5, RDATA=0.
- Misaligned word: ADDR=0x3001, SIZE=10. Response: RSP_VALID and ERR=1 at t+1; BUS_RD and BUS_WE never asserted. SIZE=11 at ADDR=0 gives the same result.
- Timeout: TIMEOUT_CYC=4, no ack. Response: BUS_RD high exactly 4 cycles, RSP_VALID with ERR=1 next; a stray BUS_ACK in IDLE afterwards causes no response.
- RST asserted in the second BUSY cycle. Response: strobes are 0 after the next edge, no RSP_VALID, MEM_REQ_READY=1 one cycle after RST is released; the following word load completes normally.
